// File: rtl/axi_word_wt_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_word_wt_buffer_pkg
// Description : Default geometry for the word write-posting buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_word_wt_buffer_pkg;

    localparam int c_def_addr_width = 32;
    localparam int c_def_data_width = 32;
    localparam int c_def_depth      = 4;

endpackage : axi_word_wt_buffer_pkg
`default_nettype wire

// File: rtl/axi_word_wt_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module      : wt_buf_mem
// Description : DEPTH-entry register file with one write port and one async
//               read port. Contents are cleared on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module wt_buf_mem
    import axi_word_wt_buffer_pkg::*;
#(
    parameter int DEPTH   = c_def_depth,
    parameter int ENTRY_W = c_def_addr_width - 2 + c_def_data_width
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [ENTRY_W-1:0]         wr_entry,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [ENTRY_W-1:0]         rd_entry
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = r_mem[rd_idx];

endmodule : wt_buf_mem
`default_nettype wire

// File: rtl/axi_word_wt_buffer.sv
`default_nettype none
// ============================================================================
// Module      : axi_word_wt_buffer
// Description : In-order write-posting queue in front of the word writer,
//               merging a repeated write to the newest non-head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_word_wt_buffer
    import axi_word_wt_buffer_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH = c_def_addr_width,
    parameter int AXI4_DATA_WIDTH = c_def_data_width,
    parameter int DEPTH           = c_def_depth
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         wr_valid_i,
    input  logic [AXI4_ADDR_WIDTH-3:0]   wr_word_addr_i,
    input  logic [AXI4_DATA_WIDTH-1:0]   wr_data_i,
    output logic                         wr_ready_o,
    output logic                         wt_req_o,
    output logic [AXI4_ADDR_WIDTH-3:0]   wt_word_addr_o,
    output logic [AXI4_DATA_WIDTH-1:0]   wt_data_o,
    input  logic                         wt_gnt_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         merge_o
);

    localparam int c_word_w = AXI4_ADDR_WIDTH - 2;
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam int c_entry_w = c_word_w + AXI4_DATA_WIDTH;

    typedef struct packed {
        logic [c_word_w-1:0]        word_addr;
        logic [AXI4_DATA_WIDTH-1:0] data;
    } entry_t;

    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_empty;
    logic                r_full;
    logic                r_merge;
    logic [c_word_w-1:0] r_tail_addr;

    logic                w_accept;
    logic                w_merge;
    logic                w_push;
    logic                w_pop;
    logic [c_cnt_w-1:0]  w_count_nxt;
    logic [c_ptr_w-1:0]  w_wr_idx;
    entry_t              w_wr_entry;
    entry_t              w_head;

    // Newest-entry address is shadowed so the merge compare needs no second read port.
    assign w_accept = wr_valid_i && !r_full;
    assign w_merge  = w_accept && (r_count >= c_cnt_w'(2)) && (wr_word_addr_i == r_tail_addr);
    assign w_push   = w_accept && !w_merge;
    assign w_pop    = wt_gnt_i && !r_empty;

    assign w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_wr_idx    = w_merge ? (r_wr_ptr - c_ptr_w'(1)) : r_wr_ptr;

    assign w_wr_entry.word_addr = wr_word_addr_i;
    assign w_wr_entry.data      = wr_data_i;

    wt_buf_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (c_entry_w)
    ) u_mem (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .we       (w_accept),
        .wr_idx   (w_wr_idx),
        .wr_entry (w_wr_entry),
        .rd_idx   (r_rd_ptr),
        .rd_entry (w_head)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_merge     <= 1'b0;
            r_tail_addr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + c_ptr_w'(1);
                r_tail_addr <= wr_word_addr_i;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_cnt_w'(DEPTH));
            r_merge <= w_merge;
        end
    end

    assign wr_ready_o     = !r_full;
    assign wt_req_o       = !r_empty;
    assign wt_word_addr_o = w_head.word_addr;
    assign wt_data_o      = w_head.data;
    assign count_o        = r_count;
    assign empty_o        = r_empty;
    assign full_o         = r_full;
    assign merge_o        = r_merge;

endmodule : axi_word_wt_buffer
`default_nettype wire

// File: tb/tb_axi_word_wt_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_word_wt_buffer
// Description : Directed self-checking bench for axi_word_wt_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_word_wt_buffer;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [29:0] wr_word_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        wr_ready_o;
    logic        wt_req_o;
    logic [29:0] wt_word_addr_o;
    logic [31:0] wt_data_o;
    logic        wt_gnt_i = 1'b0;
    logic [2:0]  count_o;
    logic        empty_o;
    logic        full_o;
    logic        merge_o;

    int n_total = 0;
    int n_pass  = 0;

    axi_word_wt_buffer #(
        .AXI4_ADDR_WIDTH (32),
        .AXI4_DATA_WIDTH (32),
        .DEPTH           (4)
    ) dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .wr_valid_i     (wr_valid_i),
        .wr_word_addr_i (wr_word_addr_i),
        .wr_data_i      (wr_data_i),
        .wr_ready_o     (wr_ready_o),
        .wt_req_o       (wt_req_o),
        .wt_word_addr_o (wt_word_addr_o),
        .wt_data_o      (wt_data_o),
        .wt_gnt_i       (wt_gnt_i),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .merge_o        (merge_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push(input logic [29:0] a, input logic [31:0] d);
        int n = 0;
        wr_valid_i = 1'b1;
        wr_word_addr_i = a;
        wr_data_i = d;
        while (!wr_ready_o && n < 20) begin
            tick();
            n++;
        end
        check("push_ready", wr_ready_o, 1);
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic drain(input logic [29:0] a, input logic [31:0] d);
        check("drain_req", wt_req_o, 1);
        check("drain_addr", wt_word_addr_o, a);
        check("drain_data", wt_data_o, d);
        wt_gnt_i = 1'b1;
        tick();
        wt_gnt_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, wt_req_o, 0);
        check({tag, "_ready"}, wr_ready_o, 1);
        check({tag, "_empty"}, empty_o, 1);
        check({tag, "_full"}, full_o, 0);
        check({tag, "_merge"}, merge_o, 0);
        check({tag, "_count"}, count_o, 0);
        check({tag, "_addr"}, wt_word_addr_o, 0);
        check({tag, "_data"}, wt_data_o, 0);
    endtask

    initial begin
        #12;
        check_reset_vals("rst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();

        // Grant while empty has no effect
        wt_gnt_i = 1'b1;
        tick();
        wt_gnt_i = 1'b0;
        check("gnt_empty_count", count_o, 0);
        check("gnt_empty_empty", empty_o, 1);

        // Single write, granted after 5 idle cycles
        push(30'h100, 32'hDEADBEEF);
        check("single_req", wt_req_o, 1);
        check("single_addr", wt_word_addr_o, 30'h100);
        check("single_data", wt_data_o, 32'hDEADBEEF);
        check("single_count", count_o, 1);
        repeat (5) tick();
        check("single_hold_req", wt_req_o, 1);
        drain(30'h100, 32'hDEADBEEF);
        check("single_empty", empty_o, 1);
        check("single_req_off", wt_req_o, 0);

        // Fill with stalled grant, fifth write held
        for (int i = 1; i <= 4; i++) push(30'h200 + 30'(i), 32'(i));
        check("fill_full", full_o, 1);
        check("fill_ready", wr_ready_o, 0);
        check("fill_count", count_o, 4);
        wr_valid_i = 1'b1;
        wr_word_addr_i = 30'h300;
        wr_data_i = 32'h5;
        tick();
        check("fill_held_count", count_o, 4);
        wt_gnt_i = 1'b1;
        tick();
        wt_gnt_i = 1'b0;
        check("fill_gnt_ready", wr_ready_o, 1);
        check("fill_gnt_count", count_o, 3);
        tick();
        wr_valid_i = 1'b0;
        check("fill_accept_count", count_o, 4);
        drain(30'h202, 32'h2);
        drain(30'h203, 32'h3);
        drain(30'h204, 32'h4);
        drain(30'h300, 32'h5);
        check("fill_empty", empty_o, 1);

        // Merge into newest non-head entry
        push(30'h10, 32'h1);
        push(30'h20, 32'h2);
        push(30'h20, 32'h55);
        check("merge_pulse", merge_o, 1);
        check("merge_count", count_o, 2);
        tick();
        check("merge_pulse_end", merge_o, 0);
        drain(30'h10, 32'h1);
        drain(30'h20, 32'h55);
        check("merge_empty", empty_o, 1);

        // Head entry is never merged
        push(30'h10, 32'h7);
        push(30'h10, 32'h8);
        check("nomerge_pulse", merge_o, 0);
        check("nomerge_count", count_o, 2);
        drain(30'h10, 32'h7);
        drain(30'h10, 32'h8);

        // Head stays stable while grant is withheld
        push(30'h40, 32'hAA);
        for (int k = 0; k < 10; k++) begin
            wr_valid_i = 1'b1;
            wr_word_addr_i = 30'h41 + 30'(k);
            wr_data_i = 32'(k);
            tick();
            check("stable_addr", wt_word_addr_o, 30'h40);
            check("stable_data", wt_data_o, 32'hAA);
        end
        wr_valid_i = 1'b0;
        check("stable_count", count_o, 4);
        drain(30'h40, 32'hAA);
        drain(30'h41, 32'h0);
        drain(30'h42, 32'h1);
        drain(30'h43, 32'h2);

        // Simultaneous push and grant at count 2
        push(30'h60, 32'h1);
        push(30'h61, 32'h2);
        wr_valid_i = 1'b1;
        wr_word_addr_i = 30'h62;
        wr_data_i = 32'h3;
        wt_gnt_i = 1'b1;
        tick();
        check("simul_count", count_o, 2);
        check("simul_addr", wt_word_addr_o, 30'h61);
        check("simul_data", wt_data_o, 32'h2);
        wr_word_addr_i = 30'h62;
        wr_data_i = 32'h33;
        tick();
        wr_valid_i = 1'b0;
        wt_gnt_i = 1'b0;
        check("simul_merge_pulse", merge_o, 1);
        check("simul_merge_count", count_o, 1);
        drain(30'h62, 32'h33);
        check("simul_empty", empty_o, 1);

        // Pointer wrap: 10 writes streamed through with continuous grant
        for (int i = 0; i < 10; i++) begin
            wr_valid_i = 1'b1;
            wr_word_addr_i = 30'h80 + 30'(i);
            wr_data_i = 32'hC000 + 32'(i);
            wt_gnt_i = (i > 0);
            tick();
            check("wrap_addr", wt_word_addr_o, 30'h80 + 30'(i));
            check("wrap_data", wt_data_o, 32'hC000 + 32'(i));
            check("wrap_count", count_o, 1);
        end
        wr_valid_i = 1'b0;
        wt_gnt_i = 1'b1;
        tick();
        wt_gnt_i = 1'b0;
        check("wrap_empty", empty_o, 1);

        // Reset mid-operation with 3 entries queued
        push(30'hA0, 32'hA0);
        push(30'hA1, 32'hA1);
        push(30'hA2, 32'hA2);
        check("pre_rst_count", count_o, 3);
        #2;
        ARESETn = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        push(30'h90, 32'h9);
        push(30'h91, 32'hA);
        check("post_rst_count", count_o, 2);
        drain(30'h90, 32'h9);
        drain(30'h91, 32'hA);
        check("post_rst_empty", empty_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_axi_word_wt_buffer
`default_nettype wire
